// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants, requester bundle type and helpers for the writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned NUM_REGS    = 32;
  // Widest writeback data the bundle type can carry; DWIDTH must not exceed it.
  localparam int unsigned WB_DATA_MAX = 64;

  localparam logic [WB_DATA_MAX-1:0] ZERO = '0;

  // One requester's write payload.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]  rd;
    logic [WB_DATA_MAX-1:0] data;
  } wb_req_t;

  // One-hot decode of a register address into the in-flight write mask.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst   clock and synchronous active-high reset (pointer -> 0)
//   req        per-requester request vector
//   enable     gates all grants and pointer movement
//   grant      combinational one-hot (or zero) grant
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;

  // Cyclic scan starting at ptr; first requester found wins and the
  // pointer moves just past it.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant    = '0;
    ptr_next = ptr;
    idx      = 0;
    found    = 1'b0;
    if (enable) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
          ptr_next   = PTR_W'((idx + 1) % NREQ);
        end
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single register-file write
// port. The accepted write is registered for one cycle and also exported as
// an in-flight mask for decode-stage forwarding.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid_i    per-requester write request
//   req_rd_i       packed destination registers, requester i at [i*5 +: 5]
//   req_data_i     packed write data, requester i at [i*DWIDTH +: DWIDTH]
//   req_ready_o    combinational one-hot grant
//   stall_i        blocks all grants
//   flush_i        squashes the write being registered this cycle
//   regwren_o      register-file write enable
//   rd_o           register-file write address
//   datawb_o       register-file write data
//   pend_o         one-hot of rd_o while regwren_o is high
// DWIDTH may be at most WB_DATA_MAX.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREQ   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [NREQ*REG_ADDR_W-1:0]   req_rd_i,
  input  logic [NREQ*DWIDTH-1:0]       req_data_i,
  output logic [NREQ-1:0]              req_ready_o,
  input  logic                         stall_i,
  input  logic                         flush_i,
  output logic                         regwren_o,
  output logic [REG_ADDR_W-1:0]        rd_o,
  output logic [DWIDTH-1:0]            datawb_o,
  output logic [NUM_REGS-1:0]          pend_o
);

  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic            write_en;
  wb_req_t         sel;

  // Reset and stall both suppress grants; the pointer only moves on a grant.
  assign arb_en = !rst && !stall_i;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid_i),
    .enable (arb_en),
    .grant  (grant)
  );

  assign req_ready_o = grant;

  // Mux the granted requester's payload.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel.rd   = req_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
        sel.data = WB_DATA_MAX'(req_data_i[i*DWIDTH +: DWIDTH]);
      end
    end
  end

  // A grant always completes a transfer; writes to x0 and flushed writes
  // are consumed without enabling the register file.
  assign xfer     = |grant;
  assign write_en = xfer && !flush_i && (sel.rd != '0);

  // Write stage register; address/data hold when no write is launched.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwren_o <= 1'b0;
      rd_o      <= '0;
      datawb_o  <= DWIDTH'(ZERO);
      pend_o    <= '0;
    end else begin
      regwren_o <= write_en;
      pend_o    <= write_en ? rd_onehot(sel.rd) : '0;
      if (write_en) begin
        rd_o     <= sel.rd;
        datawb_o <= DWIDTH'(sel.data);
      end
    end
  end

endmodule
